// File: rtl/amc7823_spi_master_pkg.sv
// Shared definitions for the AMC7823 SPI initiator: frame layout, command
// word fields and the transaction state encoding.
package amc7823_spi_master_pkg;

    localparam int FRAME_BITS     = 32;
    localparam int RW_BIT         = 15;
    localparam int PAGE_MSB       = 13;
    localparam int PAGE_LSB       = 12;
    localparam int START_ADDR_MSB = 11;
    localparam int START_ADDR_LSB = 6;
    localparam int END_ADDR_MSB   = 5;
    localparam int END_ADDR_LSB   = 0;
    localparam int PAGE_DATA      = 0;
    localparam int PAGE_CTRL      = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

endpackage

// File: rtl/amc7823_spi_master_half_tick.sv
// Down-counter that fires once every TSCKHALF clk cycles; it is held at its
// reload value while the initiator is idle so the first tick is a full H away.
module amc7823_spi_master_half_tick #(
    parameter int TSCKHALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'(TSCKHALF - 1);
        end else if (count == 8'd0) begin
            count <= 8'(TSCKHALF - 1);
        end else begin
            count <= count - 8'd1;
        end
    end

    assign tick = (count == 8'd0) && !clear;

endmodule

// File: rtl/amc7823_spi_master.sv
// SPI mode-0 initiator for the AMC7823: shifts {cmd,wdata} out MSB-first and
// returns the last 16 bits captured from miso; ss, sclk and mosi are registered.
module amc7823_spi_master
    import amc7823_spi_master_pkg::*;
#(
    parameter int TSCKHALF   = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    state_t      state;
    state_t      next_state;
    logic        tick;
    logic        clear_tick;
    logic [31:0] tx;
    logic [15:0] rx;
    logic [5:0]  bitcnt;

    logic accept;
    logic begin_frame;
    logic sclk_rise;
    logic sclk_fall;
    logic last_fall;
    logic hold_end;
    logic gap_tick;
    logic gap_end;

    amc7823_spi_master_half_tick #(
        .TSCKHALF(TSCKHALF)
    ) u_half_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_tick),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start)     next_state = ST_LOAD;
            ST_LOAD:                 next_state = ST_SETUP;
            ST_SETUP: if (tick)      next_state = ST_SHIFT;
            ST_SHIFT: if (last_fall) next_state = ST_HOLD;
            ST_HOLD:  if (hold_end)  next_state = ST_GAP;
            ST_GAP:   if (gap_end)   next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_tick  = (state == ST_IDLE) || (state == ST_LOAD);
        accept      = (state == ST_IDLE) && start;
        begin_frame = (state == ST_LOAD);
        sclk_rise   = tick && ((state == ST_SETUP) || ((state == ST_SHIFT) && !sclk));
        sclk_fall   = tick && (state == ST_SHIFT) && sclk;
        last_fall   = sclk_fall && (bitcnt == 6'(FRAME_BITS - 1));
        hold_end    = tick && (state == ST_HOLD);
        gap_tick    = tick && (state == ST_GAP);
        gap_end     = gap_tick && (bitcnt == 6'(GAP_HALVES - 1));
    end

    // rx keeps only the newest 16 bits, so the command-phase echo falls off the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx     <= '0;
            rx     <= '0;
            bitcnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rdata  <= '0;
            ss     <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
        end else begin
            done <= gap_end;
            if (accept) begin
                tx     <= {cmd, wdata};
                rx     <= '0;
                bitcnt <= '0;
                busy   <= 1'b1;
            end
            if (begin_frame) begin
                ss   <= 1'b0;
                mosi <= tx[31];
            end
            if (sclk_rise) begin
                sclk <= 1'b1;
            end
            if (sclk_fall) begin
                sclk   <= 1'b0;
                rx     <= {rx[14:0], miso};
                bitcnt <= bitcnt + 6'd1;
                if (!last_fall) begin
                    tx   <= {tx[30:0], 1'b0};
                    mosi <= tx[30];
                end
            end
            if (hold_end) begin
                ss     <= 1'b1;
                rdata  <= rx;
                bitcnt <= '0;
            end
            if (gap_tick) begin
                bitcnt <= bitcnt + 6'd1;
            end
            if (gap_end) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/amc7823_spi_master.md
Name: amc7823_spi_master

Overview:
FPGA-side SPI initiator for the AMC7823 housekeeping ADC/DAC. It is the counterpart of the device-side AMC7823 model.
- Accepts one 16-bit command word and one 16-bit data word per request.
- Shifts the 32-bit frame out MSB-first on mosi and captures 32 bits from miso.
- Returns the low 16 captured bits as read data.
- Sits between the local register bus (host writes cmd/wdata and pulses start) and the digitizer-board SPI pins ss, sclk, mosi, miso.

Parameters:
- TSCKHALF, 4: clk cycles per sclk half-period (H). Legal range 2..255.
- GAP_HALVES, 2: minimum ss-high time between frames, in units of H.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request strobe; honoured only when busy=0.
- cmd  in  16  AMC7823 command word. Bit15=R/W (1=read); page and address fields per amc7823_defs.vh.
- wdata  in  16  data word for writes; don't-care for reads, but still shifted out.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of transaction.
- rdata  out  16  captured bits [15:0] of the last frame; held until the next done.
- ss  out  1  chip select, active low.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial data to device.
- miso  in  1  serial data from device.

Behaviour:
- Reset values (clk edge with rst=1):
  - ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0.
  - State=IDLE; counters and shift registers cleared.
  - rst wins over a simultaneous start.
  - rst mid-frame aborts immediately: ss=1 on the next edge, no done pulse, rdata unchanged from reset value 0.
- SPI mode 0: mosi changes on the falling sclk edge; the device samples on the rising edge. The master samples miso on the clk edge where it drives sclk 1->0, which is mid-way between device output updates.
- Half-period tick: counter reloads to H-1 and fires every H clk cycles while not IDLE.
- State machine:
  - IDLE: ss=1, sclk=0.
    - start=1 at edge 0: latch tx={cmd,wdata}, bitcnt=0, busy=1.
    - Go to SETUP at edge 1, with ss=0 and mosi=tx[31].
  - SETUP: hold H cycles. sclk=1 at edge 1+H; go to SHIFT.
  - SHIFT: sclk toggles on every tick.
    - On each 1->0 edge: rx<={rx[30:0],miso}, tx shifts left, mosi=next bit, bitcnt++.
    - The 32nd falling edge (edge 1+64H) leaves sclk=0 and goes to HOLD. mosi holds the last value.
  - HOLD: H cycles, then ss=1 at edge 1+65H. rdata<=rx[15:0] on that same edge. Go to GAP.
  - GAP: GAP_HALVES*H cycles, then done=1 and busy=0 at edge 1+(65+GAP_HALVES)H. Go to IDLE.
- Total latency with defaults: done 1+67*4 = 269 clk cycles after the start edge. Next start is accepted in the cycle after done.
- start while busy=1 is ignored; there is no queueing. cmd/wdata changes after acceptance have no effect.
- sclk never exceeds clk/(2*TSCKHALF). No glitches: sclk, ss and mosi are all registered outputs.
- rx[31:16] (command-phase echo) is discarded.

Decomposition:
- amc7823_defs.vh holds:
  - AMC7823_RW_BIT=15; page field [13:12], start address [11:6], end address [5:0].
  - Page constants: PAGE_DATA=0, PAGE_CTRL=1.
  - FRAME_BITS=32.
- One natural sub-module: spi_half_tick (down-counter producing the H-cycle tick, cleared on rst and in IDLE).
- The FSM and shift registers stay in the top module.

Test Plan:
1. Reset during operation: start, then rst=1 at cycle 100 -> next edge ss=1, sclk=0, busy=0; no done pulse; rdata=0.
2. Single read against the AMC7823 device model (miso toggles on each sclk rising edge, initial 0), cmd=0x8040, H=4 -> exactly 32 sclk rising edges while ss=0; done at cycle 269; rdata=0xAAAA.
3. Write cmd=0x1234, wdata=0xC3A5 -> bits sampled by the bench on sclk rising edges equal 0x1234C3A5 MSB-first. ss low exactly 65*H cycles; ss high ≥ 2H before the next frame.
4. Back-to-back: start pulsed in the cycle after done -> accepted. Second rdata=0xAAAA (model returns to the same phase after 32 toggles). Extra start pulses during busy produce no additional frames.
5. Parameter sweep TSCKHALF=2 and 7 -> sclk half-period measures 2 and 7 clk cycles; done latency 1+67H (135 and 470).
6. start coincident with rst=1 -> no frame, ss stays 1, busy stays 0.
